// File: rtl/memory_stage_pkg.sv
// -----------------------------------------------------------------------------
// mem_pkg: shared definitions for the memory stage.
//   - funct3 encodings for loads and stores
//   - writeback-select encodings
//   - memory-stage FSM state type
//   - helper functions for access legality, byte enables and store lane data
// -----------------------------------------------------------------------------
package mem_pkg;

  localparam logic [2:0] F3_LB  = 3'b000;
  localparam logic [2:0] F3_LH  = 3'b001;
  localparam logic [2:0] F3_LW  = 3'b010;
  localparam logic [2:0] F3_LBU = 3'b100;
  localparam logic [2:0] F3_LHU = 3'b101;
  localparam logic [2:0] F3_SB  = 3'b000;
  localparam logic [2:0] F3_SH  = 3'b001;
  localparam logic [2:0] F3_SW  = 3'b010;

  localparam logic [1:0] WBSEL_ALU = 2'b00;
  localparam logic [1:0] WBSEL_MEM = 2'b01;
  localparam logic [1:0] WBSEL_PC4 = 2'b10;

  typedef enum logic [1:0] {
    IDLE = 2'b00,
    REQ  = 2'b01,
    WAIT = 2'b10
  } state_t;

  // Illegal encoding or an address not aligned to the access size.
  function automatic logic access_fault(input logic [2:0] f3,
                                        input logic       is_store,
                                        input logic [1:0] off);
    logic illegal;
    logic misaligned;
    if (is_store) begin
      illegal = (f3 != F3_SB) && (f3 != F3_SH) && (f3 != F3_SW);
    end else begin
      illegal = (f3 == 3'b011) || (f3 == 3'b110) || (f3 == 3'b111);
    end
    case (f3[1:0])
      2'b01:   misaligned = off[0];
      2'b10:   misaligned = (off != 2'b00);
      default: misaligned = 1'b0;
    endcase
    return illegal | misaligned;
  endfunction

  // Byte lanes touched by an access; size comes from funct3[1:0].
  function automatic logic [3:0] access_be(input logic [2:0] f3,
                                           input logic [1:0] off);
    logic [3:0] be;
    case (f3[1:0])
      2'b00:   be = 4'b0001 << off;
      2'b01:   be = 4'b0011 << off;
      2'b10:   be = 4'b1111;
      default: be = 4'b0000;
    endcase
    return be;
  endfunction

  // Replicate store data across all lanes so the enabled lanes carry it.
  function automatic logic [31:0] store_wdata(input logic [2:0]  f3,
                                              input logic [31:0] rs2);
    logic [31:0] wd;
    case (f3[1:0])
      2'b00:   wd = {4{rs2[7:0]}};
      2'b01:   wd = {2{rs2[15:0]}};
      default: wd = rs2;
    endcase
    return wd;
  endfunction

endpackage

// File: rtl/memory_stage_if.sv
// -----------------------------------------------------------------------------
// memory_stage_if: execute-side handshake, writeback bundle and data-memory
// port of the memory stage.
//   slave  : the memory stage's view (consumes execute bundle, drives dmem)
//   master : the environment's view (execute, writeback and data memory)
// -----------------------------------------------------------------------------
interface memory_stage_if #(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32
);
  logic              valid_i;
  logic              ready_o;
  logic [AWIDTH-1:0] pc_i;
  logic [DWIDTH-1:0] alu_res_i;
  logic [DWIDTH-1:0] rs2_data_i;
  logic [2:0]        funct3_i;
  logic              memren_i;
  logic              memwen_i;
  logic [1:0]        wbsel_i;
  logic              brtaken_i;
  logic              valid_o;
  logic [AWIDTH-1:0] pc_o;
  logic [DWIDTH-1:0] alu_res_o;
  logic [DWIDTH-1:0] memory_data_o;
  logic [1:0]        wbsel_o;
  logic              brtaken_o;
  logic              access_fault_o;
  logic              dmem_req_o;
  logic              dmem_we_o;
  logic [AWIDTH-1:0] dmem_addr_o;
  logic [3:0]        dmem_be_o;
  logic [DWIDTH-1:0] dmem_wdata_o;
  logic              dmem_gnt_i;
  logic              dmem_rvalid_i;
  logic [DWIDTH-1:0] dmem_rdata_i;

  modport slave (
    input  valid_i, pc_i, alu_res_i, rs2_data_i, funct3_i, memren_i, memwen_i,
           wbsel_i, brtaken_i, dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i,
    output ready_o, valid_o, pc_o, alu_res_o, memory_data_o, wbsel_o, brtaken_o,
           access_fault_o, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o,
           dmem_wdata_o
  );

  modport master (
    output valid_i, pc_i, alu_res_i, rs2_data_i, funct3_i, memren_i, memwen_i,
           wbsel_i, brtaken_i, dmem_gnt_i, dmem_rvalid_i, dmem_rdata_i,
    input  ready_o, valid_o, pc_o, alu_res_o, memory_data_o, wbsel_o, brtaken_o,
           access_fault_o, dmem_req_o, dmem_we_o, dmem_addr_o, dmem_be_o,
           dmem_wdata_o
  );
endinterface

// File: rtl/memory_stage_load_align.sv
// -----------------------------------------------------------------------------
// load_align: combinational load formatter.
//   rdata  in  32  raw word from data memory
//   offset in  2   byte offset of the access (addr[1:0])
//   funct3 in  3   load size/sign
//   data   out 32  selected byte/half/word, sign- or zero-extended
// -----------------------------------------------------------------------------
module load_align
  import mem_pkg::*;
(
  input  logic [31:0] rdata,
  input  logic [1:0]  offset,
  input  logic [2:0]  funct3,
  output logic [31:0] data
);
  logic [7:0]  byte_s;
  logic [15:0] half_s;

  // Select the addressed byte and half, then extend per funct3.
  always_comb begin
    case (offset)
      2'b00:   byte_s = rdata[7:0];
      2'b01:   byte_s = rdata[15:8];
      2'b10:   byte_s = rdata[23:16];
      2'b11:   byte_s = rdata[31:24];
      default: byte_s = 8'h00;
    endcase
    if (offset[1]) begin
      half_s = rdata[31:16];
    end else begin
      half_s = rdata[15:0];
    end
    case (funct3)
      F3_LB:   data = {{24{byte_s[7]}}, byte_s};
      F3_LBU:  data = {24'h000000, byte_s};
      F3_LH:   data = {{16{half_s[15]}}, half_s};
      F3_LHU:  data = {16'h0000, half_s};
      F3_LW:   data = rdata;
      default: data = 32'h0000_0000;
    endcase
  end
endmodule

// File: rtl/memory_stage.sv
// -----------------------------------------------------------------------------
// memory_stage: pipelined data-memory access stage (execute -> writeback).
//   clk     in  rising-edge clock
//   reset_n in  asynchronous active-low reset
//   bus     slave modport of memory_stage_if: execute handshake (valid/ready +
//           bundle), registered writeback bundle (valid_o pulse + fields) and
//           the req/gnt/rvalid data-memory port.
// Non-memory and faulting ops complete the cycle after capture; legal memory
// ops go IDLE -> REQ (until gnt) -> [WAIT until rvalid for loads] -> IDLE.
// -----------------------------------------------------------------------------
module memory_stage
  import mem_pkg::*;
#(
  parameter int DWIDTH = 32,
  parameter int AWIDTH = 32
) (
  input logic           clk,
  input logic           reset_n,
  memory_stage_if.slave bus
);
  state_t state_r, state_next_s;
  logic ready_s, req_s, we_s;
  logic [3:0] be_s;
  logic capture_s, mem_op_s, fault_s, start_mem_s;
  logic done_direct_s, done_store_s, done_load_s;
  logic [DWIDTH-1:0] load_data_s;

  // Bundle of the instruction in flight through REQ/WAIT.
  logic [AWIDTH-1:0] p_pc_r;
  logic [DWIDTH-1:0] p_alu_r;
  logic [1:0]        p_wbsel_r;
  logic              p_br_r;
  logic [2:0]        p_f3_r;
  logic [AWIDTH-1:0] addr_r;
  logic [3:0]        be_r;
  logic [DWIDTH-1:0] wdata_r;
  logic              we_r;

  // Registered writeback bundle.
  logic              valid_r;
  logic [AWIDTH-1:0] pc_r;
  logic [DWIDTH-1:0] alu_r;
  logic [DWIDTH-1:0] mdata_r;
  logic [1:0]        wbsel_r;
  logic              br_r;
  logic              fault_r;

  assign capture_s   = bus.valid_i & ready_s;
  assign mem_op_s    = bus.memren_i | bus.memwen_i;
  // memwen wins when both are set, so legality is judged as a store.
  assign fault_s     = mem_op_s & access_fault(bus.funct3_i, bus.memwen_i, bus.alu_res_i[1:0]);
  assign start_mem_s = capture_s & mem_op_s & ~fault_s;
  assign done_direct_s = capture_s & ~start_mem_s;
  assign done_store_s  = (state_r == REQ) & bus.dmem_gnt_i & we_r;
  // rvalid only counts in WAIT; a beat coincident with gnt is ignored.
  assign done_load_s   = (state_r == WAIT) & bus.dmem_rvalid_i;

  load_align u_load_align (
    .rdata  (bus.dmem_rdata_i),
    .offset (p_alu_r[1:0]),
    .funct3 (p_f3_r),
    .data   (load_data_s)
  );

  // FSM state register.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // FSM next-state logic.
  always_comb begin
    state_next_s = state_r;
    case (state_r)
      IDLE: begin
        if (start_mem_s) state_next_s = REQ;
        else             state_next_s = IDLE;
      end
      REQ: begin
        if (bus.dmem_gnt_i) state_next_s = we_r ? IDLE : WAIT;
        else                state_next_s = REQ;
      end
      WAIT: begin
        if (bus.dmem_rvalid_i) state_next_s = IDLE;
        else                   state_next_s = WAIT;
      end
      default: state_next_s = IDLE;
    endcase
  end

  // FSM outputs: handshake and request qualifiers decoded from state.
  always_comb begin
    ready_s = (state_r == IDLE);
    req_s   = (state_r == REQ);
    if (req_s) begin
      be_s = be_r;
      we_s = we_r;
    end else begin
      be_s = 4'b0000;
      we_s = 1'b0;
    end
  end

  // Latch the request and pending bundle when a memory op is accepted.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      p_pc_r    <= '0;
      p_alu_r   <= '0;
      p_wbsel_r <= 2'b00;
      p_br_r    <= 1'b0;
      p_f3_r    <= 3'b000;
      addr_r    <= '0;
      be_r      <= 4'b0000;
      wdata_r   <= '0;
      we_r      <= 1'b0;
    end else if (start_mem_s) begin
      p_pc_r    <= bus.pc_i;
      p_alu_r   <= bus.alu_res_i;
      p_wbsel_r <= bus.wbsel_i;
      p_br_r    <= bus.brtaken_i;
      p_f3_r    <= bus.funct3_i;
      addr_r    <= {bus.alu_res_i[AWIDTH-1:2], 2'b00};
      be_r      <= access_be(bus.funct3_i, bus.alu_res_i[1:0]);
      wdata_r   <= store_wdata(bus.funct3_i, bus.rs2_data_i);
      we_r      <= bus.memwen_i;
    end
  end

  // Writeback bundle: one-cycle valid pulse, fields held until next completion.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      valid_r <= 1'b0;
      pc_r    <= '0;
      alu_r   <= '0;
      mdata_r <= '0;
      wbsel_r <= 2'b00;
      br_r    <= 1'b0;
      fault_r <= 1'b0;
    end else begin
      valid_r <= done_direct_s | done_store_s | done_load_s;
      if (done_direct_s) begin
        pc_r    <= bus.pc_i;
        alu_r   <= bus.alu_res_i;
        mdata_r <= '0;
        wbsel_r <= bus.wbsel_i;
        br_r    <= bus.brtaken_i;
        fault_r <= fault_s;
      end else if (done_store_s | done_load_s) begin
        pc_r    <= p_pc_r;
        alu_r   <= p_alu_r;
        mdata_r <= done_load_s ? load_data_s : '0;
        wbsel_r <= p_wbsel_r;
        br_r    <= p_br_r;
        fault_r <= 1'b0;
      end
    end
  end

  assign bus.ready_o        = ready_s;
  assign bus.dmem_req_o     = req_s;
  assign bus.dmem_we_o      = we_s;
  assign bus.dmem_be_o      = be_s;
  assign bus.dmem_addr_o    = addr_r;
  assign bus.dmem_wdata_o   = wdata_r;
  assign bus.valid_o        = valid_r;
  assign bus.pc_o           = pc_r;
  assign bus.alu_res_o      = alu_r;
  assign bus.memory_data_o  = mdata_r;
  assign bus.wbsel_o        = wbsel_r;
  assign bus.brtaken_o      = br_r;
  assign bus.access_fault_o = fault_r;
endmodule

// File: tb/tb_memory_stage.sv
// -----------------------------------------------------------------------------
// tb_memory_stage: self-checking bench for memory_stage. Inputs are driven and
// outputs sampled 1ns after the rising edge. Expected values come from an
// arithmetic reference model of the access rules.
// -----------------------------------------------------------------------------
module tb_memory_stage;
  logic clk = 1'b0;
  logic reset_n = 1'b0;
  int   n_cmp = 0;
  int   n_err = 0;

  always #5 clk = ~clk;

  memory_stage_if #(.DWIDTH(32), .AWIDTH(32)) bus ();

  memory_stage #(.DWIDTH(32), .AWIDTH(32)) dut (
    .clk     (clk),
    .reset_n (reset_n),
    .bus     (bus.slave)
  );

  // Results of the last run_op.
  int          r_lat;
  logic [31:0] r_pc, r_alu, r_mdata, r_addr, r_wdata;
  logic [1:0]  r_wbsel;
  logic [3:0]  r_be;
  logic        r_br, r_fault, r_we, r_saw_req, r_req_stable, r_ready_low;
  logic        r_ready_cap, r_pulse_ok, r_hold_ok;

  // ---------------- reference model ----------------
  function automatic logic m_fault(input logic [2:0] f3, input logic ren, wen,
                                   input logic [31:0] addr);
    int size;
    logic legal;
    if (!(ren || wen)) return 1'b0;
    if (wen) legal = (f3 inside {3'd0, 3'd1, 3'd2});
    else     legal = (f3 inside {3'd0, 3'd1, 3'd2, 3'd4, 3'd5});
    size = 1 << f3[1:0];
    return !legal || ((addr % size) != 0);
  endfunction

  function automatic logic [31:0] m_load(input logic [31:0] rdata, addr,
                                         input logic [2:0] f3);
    logic [31:0] v;
    case (f3)
      3'd0, 3'd4: begin
        v = (rdata >> (8 * addr[1:0])) & 32'hFF;
        if (f3 == 3'd0 && v >= 32'd128) v = v - 32'd256;
      end
      3'd1, 3'd5: begin
        v = (rdata >> (16 * addr[1])) & 32'hFFFF;
        if (f3 == 3'd1 && v >= 32'h8000) v = v | 32'hFFFF_0000;
      end
      default: v = rdata;
    endcase
    return v;
  endfunction

  function automatic logic [3:0] m_be(input logic [2:0] f3, input logic [31:0] addr);
    int n;
    n = 1 << f3[1:0];
    return 4'(((1 << n) - 1) << addr[1:0]);
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3, input logic [31:0] rs2);
    if (f3[1:0] == 2'd0) return (rs2 & 32'hFF) * 32'h0101_0101;
    if (f3[1:0] == 2'd1) return (rs2 & 32'hFFFF) * 32'h0001_0001;
    return rs2;
  endfunction

  // ---------------- driver ----------------
  task automatic idle_inputs();
    bus.valid_i = 1'b0; bus.pc_i = 32'h0; bus.alu_res_i = 32'h0;
    bus.rs2_data_i = 32'h0; bus.funct3_i = 3'd0; bus.memren_i = 1'b0;
    bus.memwen_i = 1'b0; bus.wbsel_i = 2'd0; bus.brtaken_i = 1'b0;
    bus.dmem_gnt_i = 1'b0; bus.dmem_rvalid_i = 1'b0; bus.dmem_rdata_i = 32'h0;
  endtask

  // Present one bundle, then act as a memory granting after gdly request
  // cycles and returning rdata rdly cycles after the grant. A stray rvalid
  // with wrong data is driven in the grant cycle.
  task automatic run_op(input logic [31:0] pc, alu, rs2, input logic [2:0] f3,
                        input logic ren, wen, input logic [1:0] wbsel,
                        input logic br, input int gdly, rdly,
                        input logic [31:0] rdata);
    int reqn = 0;
    int waitn = 0;
    logic granted = 1'b0;
    bus.pc_i = pc; bus.alu_res_i = alu; bus.rs2_data_i = rs2; bus.funct3_i = f3;
    bus.memren_i = ren; bus.memwen_i = wen; bus.wbsel_i = wbsel;
    bus.brtaken_i = br; bus.valid_i = 1'b1;
    r_ready_cap = bus.ready_o;
    r_lat = -1; r_saw_req = 1'b0; r_req_stable = 1'b1; r_ready_low = 1'b1;
    r_pulse_ok = 1'b0; r_hold_ok = 1'b0;
    @(posedge clk); #1;
    bus.valid_i = 1'b0; bus.pc_i = $urandom; bus.alu_res_i = $urandom;
    bus.rs2_data_i = $urandom; bus.wbsel_i = 2'(~wbsel); bus.brtaken_i = ~br;
    for (int cyc = 1; cyc <= 200; cyc++) begin
      bus.dmem_gnt_i = 1'b0; bus.dmem_rvalid_i = 1'b0; bus.dmem_rdata_i = $urandom;
      if (bus.valid_o) begin
        r_lat = cyc; r_pc = bus.pc_o; r_alu = bus.alu_res_o;
        r_mdata = bus.memory_data_o; r_wbsel = bus.wbsel_o;
        r_br = bus.brtaken_o; r_fault = bus.access_fault_o;
        break;
      end
      if (bus.ready_o) r_ready_low = 1'b0;
      if (bus.dmem_req_o) begin
        if (!r_saw_req) begin
          r_saw_req = 1'b1; r_addr = bus.dmem_addr_o; r_be = bus.dmem_be_o;
          r_wdata = bus.dmem_wdata_o; r_we = bus.dmem_we_o;
        end else if (r_addr !== bus.dmem_addr_o || r_be !== bus.dmem_be_o ||
                     r_wdata !== bus.dmem_wdata_o || r_we !== bus.dmem_we_o) begin
          r_req_stable = 1'b0;
        end
        if (reqn == gdly) begin
          bus.dmem_gnt_i = 1'b1; bus.dmem_rvalid_i = 1'b1;
          bus.dmem_rdata_i = ~rdata; granted = 1'b1;
        end
        reqn++;
      end else if (granted) begin
        waitn++;
        if (waitn == rdly) begin
          bus.dmem_rvalid_i = 1'b1; bus.dmem_rdata_i = rdata;
        end
      end
      @(posedge clk); #1;
    end
    bus.dmem_gnt_i = 1'b0; bus.dmem_rvalid_i = 1'b0;
    if (r_lat > 0) begin
      @(posedge clk); #1;
      r_pulse_ok = !bus.valid_o;
      r_hold_ok = (bus.pc_o === r_pc) && (bus.alu_res_o === r_alu) &&
                  (bus.memory_data_o === r_mdata) && (bus.access_fault_o === r_fault);
    end
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    idle_inputs();
    reset_n = 1'b0;
    repeat (2) @(posedge clk);
    #1;
    n_cmp++; if (bus.valid_o !== 1'b0 || bus.dmem_req_o !== 1'b0 || bus.dmem_we_o !== 1'b0) begin
      n_err++; $display("FAIL reset_ctrl: valid=%b req=%b we=%b, need 0/0/0", bus.valid_o, bus.dmem_req_o, bus.dmem_we_o); end
    n_cmp++; if (bus.access_fault_o !== 1'b0 || bus.brtaken_o !== 1'b0 || bus.dmem_be_o !== 4'h0) begin
      n_err++; $display("FAIL reset_flags: fault=%b br=%b be=%h, need 0/0/0", bus.access_fault_o, bus.brtaken_o, bus.dmem_be_o); end
    n_cmp++; if ((bus.pc_o | bus.alu_res_o | bus.memory_data_o | bus.dmem_addr_o | bus.dmem_wdata_o) !== 32'h0 || bus.wbsel_o !== 2'd0) begin
      n_err++; $display("FAIL reset_data: pc=%h alu=%h md=%h addr=%h wd=%h wbsel=%h, need all 0", bus.pc_o, bus.alu_res_o, bus.memory_data_o, bus.dmem_addr_o, bus.dmem_wdata_o, bus.wbsel_o); end
    n_cmp++; if (bus.ready_o !== 1'b1) begin
      n_err++; $display("FAIL reset_ready: got %b need 1", bus.ready_o); end
    reset_n = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_nonmem_stream();
    logic [31:0] vals [3] = '{32'h1234_5678, 32'hFFFF_FFF0, 32'h0000_FF00};
    for (int i = 0; i < 3; i++) begin
      bus.valid_i = 1'b1; bus.alu_res_i = vals[i]; bus.pc_i = 32'h100 + 32'(4 * i);
      bus.funct3_i = 3'($urandom); bus.memren_i = 1'b0; bus.memwen_i = 1'b0;
      bus.wbsel_i = 2'd0; bus.brtaken_i = 1'(i);
      n_cmp++; if (bus.ready_o !== 1'b1) begin
        n_err++; $display("FAIL stream_ready[%0d]: got %b need 1", i, bus.ready_o); end
      @(posedge clk); #1;
      n_cmp++; if (bus.valid_o !== 1'b1 || bus.alu_res_o !== vals[i] || bus.pc_o !== 32'h100 + 32'(4 * i) || bus.brtaken_o !== 1'(i)) begin
        n_err++; $display("FAIL stream_out[%0d]: valid=%b alu=%h pc=%h br=%b, need 1/%h/%h/%b", i, bus.valid_o, bus.alu_res_o, bus.pc_o, bus.brtaken_o, vals[i], 32'h100 + 32'(4 * i), 1'(i)); end
      n_cmp++; if (bus.memory_data_o !== 32'h0 || bus.dmem_req_o !== 1'b0 || bus.access_fault_o !== 1'b0) begin
        n_err++; $display("FAIL stream_mem[%0d]: md=%h req=%b fault=%b, need 0/0/0", i, bus.memory_data_o, bus.dmem_req_o, bus.access_fault_o); end
    end
    bus.valid_i = 1'b0;
    @(posedge clk); #1;
    n_cmp++; if (bus.valid_o !== 1'b0) begin
      n_err++; $display("FAIL stream_end: valid=%b need 0", bus.valid_o); end
  endtask

  task automatic test_lb();
    run_op(32'h400, 32'h2003, 32'h0, 3'd0, 1'b1, 1'b0, 2'b01, 1'b1, 2, 3, 32'h80FF_FFFF);
    n_cmp++; if (r_addr !== 32'h2000 || r_be !== 4'b1000 || r_we !== 1'b0 || !r_req_stable) begin
      n_err++; $display("FAIL lb_req: addr=%h be=%b we=%b stable=%b, need 2000/1000/0/1", r_addr, r_be, r_we, r_req_stable); end
    n_cmp++; if (r_mdata !== 32'hFFFF_FF80 || r_lat !== 7) begin
      n_err++; $display("FAIL lb_data: md=%h lat=%0d, need ffffff80/7", r_mdata, r_lat); end
    n_cmp++; if (!r_ready_low || !r_ready_cap || !r_pulse_ok || !r_hold_ok) begin
      n_err++; $display("FAIL lb_hs: ready_low=%b ready_cap=%b pulse=%b hold=%b, need all 1", r_ready_low, r_ready_cap, r_pulse_ok, r_hold_ok); end
    n_cmp++; if (r_pc !== 32'h400 || r_wbsel !== 2'b01 || r_br !== 1'b1 || r_fault !== 1'b0) begin
      n_err++; $display("FAIL lb_fields: pc=%h wbsel=%b br=%b fault=%b, need 400/01/1/0", r_pc, r_wbsel, r_br, r_fault); end
  endtask

  task automatic test_lhu_lw();
    run_op(32'h404, 32'h2002, 32'h0, 3'd5, 1'b1, 1'b0, 2'b01, 1'b0, 0, 1, 32'hBEEF_1234);
    n_cmp++; if (r_mdata !== 32'h0000_BEEF || r_be !== 4'b1100 || r_lat !== 3) begin
      n_err++; $display("FAIL lhu: md=%h be=%b lat=%0d, need 0000beef/1100/3", r_mdata, r_be, r_lat); end
    run_op(32'h408, 32'h2000, 32'h0, 3'd2, 1'b1, 1'b0, 2'b01, 1'b0, 1, 2, 32'hDEAD_BEEF);
    n_cmp++; if (r_mdata !== 32'hDEAD_BEEF || r_be !== 4'b1111 || r_lat !== 5) begin
      n_err++; $display("FAIL lw: md=%h be=%b lat=%0d, need deadbeef/1111/5", r_mdata, r_be, r_lat); end
  endtask

  task automatic test_sh();
    run_op(32'h500, 32'h1002, 32'h0000_ABCD, 3'd1, 1'b0, 1'b1, 2'b00, 1'b0, 0, 1, 32'h0);
    n_cmp++; if (r_be !== 4'b1100 || r_wdata !== 32'hABCD_ABCD || r_we !== 1'b1 || r_addr !== 32'h1000) begin
      n_err++; $display("FAIL sh_req: be=%b wd=%h we=%b addr=%h, need 1100/abcdabcd/1/1000", r_be, r_wdata, r_we, r_addr); end
    n_cmp++; if (r_lat !== 2 || r_mdata !== 32'h0 || r_pc !== 32'h500 || !r_pulse_ok) begin
      n_err++; $display("FAIL sh_done: lat=%0d md=%h pc=%h pulse=%b, need 2/0/500/1", r_lat, r_mdata, r_pc, r_pulse_ok); end
  endtask

  task automatic test_misaligned();
    run_op(32'h600, 32'h1001, 32'h0, 3'd2, 1'b1, 1'b0, 2'b01, 1'b0, 0, 1, 32'hFFFF_FFFF);
    n_cmp++; if (r_saw_req !== 1'b0 || r_lat !== 1 || r_fault !== 1'b1 || r_mdata !== 32'h0) begin
      n_err++; $display("FAIL misaligned: req=%b lat=%0d fault=%b md=%h, need 0/1/1/0", r_saw_req, r_lat, r_fault, r_mdata); end
  endtask

  task automatic test_reset_mid();
    // Reset while waiting for read data.
    bus.pc_i = 32'h700; bus.alu_res_i = 32'h3000; bus.funct3_i = 3'd2;
    bus.memren_i = 1'b1; bus.memwen_i = 1'b0; bus.valid_i = 1'b1;
    @(posedge clk); #1;
    bus.valid_i = 1'b0; bus.dmem_gnt_i = 1'b1;
    @(posedge clk); #1;
    bus.dmem_gnt_i = 1'b0;
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (bus.dmem_req_o !== 1'b0 || bus.valid_o !== 1'b0 || bus.ready_o !== 1'b1) begin
      n_err++; $display("FAIL rst_wait: req=%b valid=%b ready=%b, need 0/0/1", bus.dmem_req_o, bus.valid_o, bus.ready_o); end
    @(posedge clk); #1;
    reset_n = 1'b1; bus.dmem_rvalid_i = 1'b1; bus.dmem_rdata_i = 32'h1111_2222;
    @(posedge clk); #1;
    bus.dmem_rvalid_i = 1'b0;
    for (int i = 0; i < 3; i++) begin
      n_cmp++; if (bus.valid_o !== 1'b0 || bus.ready_o !== 1'b1 || bus.memory_data_o !== 32'h0) begin
        n_err++; $display("FAIL rst_late_rvalid[%0d]: valid=%b ready=%b md=%h, need 0/1/0", i, bus.valid_o, bus.ready_o, bus.memory_data_o); end
      @(posedge clk); #1;
    end
    // Reset while the request is outstanding.
    bus.valid_i = 1'b1;
    @(posedge clk); #1;
    bus.valid_i = 1'b0;
    n_cmp++; if (bus.dmem_req_o !== 1'b1) begin
      n_err++; $display("FAIL rst_req_pre: req=%b need 1", bus.dmem_req_o); end
    #2 reset_n = 1'b0;
    #1;
    n_cmp++; if (bus.dmem_req_o !== 1'b0 || bus.dmem_be_o !== 4'h0 || bus.dmem_we_o !== 1'b0) begin
      n_err++; $display("FAIL rst_req: req=%b be=%h we=%b, need 0/0/0", bus.dmem_req_o, bus.dmem_be_o, bus.dmem_we_o); end
    @(posedge clk); #1;
    reset_n = 1'b1; bus.dmem_gnt_i = 1'b1;
    @(posedge clk); #1;
    bus.dmem_gnt_i = 1'b0;
    n_cmp++; if (bus.valid_o !== 1'b0 || bus.dmem_req_o !== 1'b0 || bus.ready_o !== 1'b1) begin
      n_err++; $display("FAIL rst_late_gnt: valid=%b req=%b ready=%b, need 0/0/1", bus.valid_o, bus.dmem_req_o, bus.ready_o); end
    idle_inputs();
  endtask

  task automatic test_random();
    for (int n = 0; n < 60; n++) begin
      logic [31:0] pc, alu, rs2, rdata, e_md;
      logic [2:0]  f3;
      logic        ren, wen, e_flt, e_req;
      logic [1:0]  wbsel;
      logic        br;
      int          kind, gd, rd, e_lat;
      kind = $urandom_range(0, 3);
      ren = (kind == 1) || (kind == 3);
      wen = (kind == 2) || (kind == 3);
      f3 = 3'($urandom); pc = $urandom; alu = $urandom; rs2 = $urandom;
      rdata = $urandom; wbsel = 2'($urandom); br = 1'($urandom);
      gd = $urandom_range(0, 3); rd = $urandom_range(1, 3);
      e_flt = m_fault(f3, ren, wen, alu);
      e_req = (ren || wen) && !e_flt;
      e_lat = !e_req ? 1 : (wen ? 2 + gd : 2 + gd + rd);
      e_md = (e_req && !wen) ? m_load(rdata, alu, f3) : 32'h0;
      run_op(pc, alu, rs2, f3, ren, wen, wbsel, br, gd, rd, rdata);
      n_cmp++; if (r_lat !== e_lat || r_mdata !== e_md || r_fault !== e_flt) begin
        n_err++; $display("FAIL rnd[%0d] result: lat=%0d md=%h fault=%b, need %0d/%h/%b (f3=%0d ren=%b wen=%b a=%h rd=%h)", n, r_lat, r_mdata, r_fault, e_lat, e_md, e_flt, f3, ren, wen, alu, rdata); end
      n_cmp++; if (r_pc !== pc || r_alu !== alu || r_wbsel !== wbsel || r_br !== br || !r_pulse_ok || !r_hold_ok) begin
        n_err++; $display("FAIL rnd[%0d] fields: pc=%h alu=%h wbsel=%b br=%b pulse=%b hold=%b, need %h/%h/%b/%b/1/1", n, r_pc, r_alu, r_wbsel, r_br, r_pulse_ok, r_hold_ok, pc, alu, wbsel, br); end
      n_cmp++; if (r_saw_req !== e_req) begin
        n_err++; $display("FAIL rnd[%0d] req: saw=%b need %b", n, r_saw_req, e_req); end
      if (e_req) begin
        n_cmp++; if (r_addr !== (alu & ~32'h3) || r_be !== m_be(f3, alu) || r_we !== wen || !r_req_stable || !r_ready_low ||
                     (wen && r_wdata !== m_wdata(f3, rs2))) begin
          n_err++; $display("FAIL rnd[%0d] bus: addr=%h be=%b we=%b wd=%h stable=%b rlow=%b, need %h/%b/%b/%h/1/1", n, r_addr, r_be, r_we, r_wdata, r_req_stable, r_ready_low, alu & ~32'h3, m_be(f3, alu), wen, m_wdata(f3, rs2)); end
      end
    end
  endtask

  initial begin
    test_reset();
    test_nonmem_stream();
    test_lb();
    test_lhu_lw();
    test_sh();
    test_misaligned();
    test_reset_mid();
    test_random();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end
endmodule
